// File: rtl/bram_burst_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bram_burst_ctrl: burst read/write sequencer for a single BRAM port.     |
// | Optional output register stage: define BRAM_CTRL_OUT_REG_EN.            |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module bram_burst_ctrl #(
  parameter int DW     = 8,
  parameter int AW     = 17,
  parameter int LW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [LW-1:0] req_len,
  input  logic          abort,
  input  logic [DW-1:0] wdata_in,
  output logic          wdata_ack,
  output logic [DW-1:0] rdata_out,
  output logic          rdata_valid,
  output logic          busy,
  output logic          done,
  output logic          enb,
  output logic          web,
  output logic [AW-1:0] addrb,
  output logic [DW-1:0] wdata_out,
  input  logic [DW-1:0] rdata_in
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        r_state;
  logic [AW-1:0]     r_addr;
  logic [LW-1:0]     r_cnt;
  logic              r_wr;
  logic              r_wr_done;
  logic [RD_LAT-1:0] r_vsr;

  logic w_beat;
  logic w_last;
  logic w_rd_issue;
  logic w_pipe_empty;

  // An abort in RUN cancels the beat of that same cycle.
  assign w_beat     = (r_state == S_RUN) & ~abort;
  assign w_last     = w_beat & (r_cnt == '0);
  assign w_rd_issue = enb & ~web;

  assign enb       = w_beat;
  assign web       = w_beat & r_wr;
  assign wdata_ack = web;
  assign addrb     = w_beat ? r_addr : '0;
  assign wdata_out = web ? wdata_in : '0;
  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_wr_done | ((r_state == S_DRAIN) & w_pipe_empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_wr      <= 1'b0;
      r_wr_done <= 1'b0;
    end else begin
      r_wr_done <= w_last & r_wr;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_state <= S_RUN;
            r_addr  <= req_addr;
            r_cnt   <= req_len;
            r_wr    <= req_wr;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state <= S_DRAIN;
          end else begin
            r_addr <= r_addr + AW'(1);
            r_cnt  <= r_cnt - LW'(1);
            if (r_cnt == '0) begin
              r_state <= r_wr ? S_IDLE : S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_pipe_empty) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Valid shift register tracks read beats through the BRAM read latency.
  generate
    if (RD_LAT == 1) begin : g_vsr_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vsr <= '0;
        end else begin
          r_vsr <= w_rd_issue;
        end
      end
    end else begin : g_vsr_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vsr <= '0;
        end else begin
          r_vsr <= {r_vsr[RD_LAT-2:0], w_rd_issue};
        end
      end
    end
  endgenerate

`ifdef BRAM_CTRL_OUT_REG_EN
  logic          r_rvalid_q;
  logic [DW-1:0] r_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid_q <= 1'b0;
      r_rdata_q  <= '0;
    end else begin
      r_rvalid_q <= r_vsr[RD_LAT-1];
      r_rdata_q  <= rdata_in;
    end
  end

  assign rdata_valid  = r_rvalid_q;
  assign rdata_out    = r_rdata_q;
  assign w_pipe_empty = ~(|r_vsr) & ~r_rvalid_q;
`else
  assign rdata_valid  = r_vsr[RD_LAT-1];
  assign rdata_out    = rdata_in;
  assign w_pipe_empty = ~(|r_vsr);
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram_burst_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_bram_burst_ctrl: bench for bram_burst_ctrl (RD_LAT=1 and RD_LAT=3).  |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_bram_burst_ctrl;
  localparam int DW = 8;
  localparam int AW = 17;
  localparam int LW = 8;
`ifdef BRAM_CTRL_OUT_REG_EN
  localparam int XO = 1;
`else
  localparam int XO = 0;
`endif

  typedef struct {
    logic          sel;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    int            abort_at;
    logic          abort_on_req;
    int            exp_beats;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid, req_wr, abort;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic [DW-1:0] wdata_in;

  logic          rr [2];
  logic          ack [2];
  logic          rv [2];
  logic          bz [2];
  logic          dn [2];
  logic          en [2];
  logic          we [2];
  logic [AW-1:0] ab [2];
  logic [DW-1:0] wo [2];
  logic [DW-1:0] ro [2];

  logic [DW-1:0] mem0 [0:(1<<AW)-1];
  logic [DW-1:0] mem3 [0:(1<<AW)-1];
  logic [DW-1:0] p1;
  logic [DW-1:0] p3 [3];

  bram_burst_ctrl #(.DW(DW), .AW(AW), .LW(LW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(rr[0]),
    .req_wr(req_wr), .req_addr(req_addr), .req_len(req_len), .abort(abort),
    .wdata_in(wdata_in), .wdata_ack(ack[0]), .rdata_out(ro[0]), .rdata_valid(rv[0]),
    .busy(bz[0]), .done(dn[0]), .enb(en[0]), .web(we[0]), .addrb(ab[0]),
    .wdata_out(wo[0]), .rdata_in(p1)
  );

  bram_burst_ctrl #(.DW(DW), .AW(AW), .LW(LW), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(rr[1]),
    .req_wr(req_wr), .req_addr(req_addr), .req_len(req_len), .abort(abort),
    .wdata_in(wdata_in), .wdata_ack(ack[1]), .rdata_out(ro[1]), .rdata_valid(rv[1]),
    .busy(bz[1]), .done(dn[1]), .enb(en[1]), .web(we[1]), .addrb(ab[1]),
    .wdata_out(wo[1]), .rdata_in(p3[2])
  );

  // Behavioural BRAMs with 1- and 3-cycle read latency.
  always @(posedge clk) begin
    if (en[0] && we[0]) mem0[ab[0]] <= wo[0];
    if (en[1] && we[1]) mem3[ab[1]] <= wo[1];
    p1    <= mem0[ab[0]];
    p3[0] <= mem3[ab[1]];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  logic          rr_s, ack_s, rv_s, bz_s, dn_s, en_s, we_s;
  logic [AW-1:0] ab_s;
  logic [DW-1:0] wo_s, ro_s;
  always_comb begin
    rr_s = rr[sel]; ack_s = ack[sel]; rv_s = rv[sel]; bz_s = bz[sel];
    dn_s = dn[sel]; en_s = en[sel]; we_s = we[sel]; ab_s = ab[sel];
    wo_s = wo[sel]; ro_s = ro[sel];
  end

  int nchk = 0;
  int nfail = 0;
  int cyc_n = 0;
  int nval, first_val, last_val;
  logic [DW-1:0] sbq [$];
  logic [DW-1:0] shadow [int];
  logic [DW-1:0] mon_exp;
  vec_t tv [16];
  vec_t rst_vec;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic void chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, sel %0d)", nm, act, exp, cyc_n, sel);
    end
  endfunction

  function automatic void chk1(input string nm, input logic act, input logic exp);
    chkw(nm, 32'(act), 32'(exp));
  endfunction

  function automatic int key_of(input logic s, input logic [AW-1:0] a);
    return (int'(s) << AW) | int'(a);
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic s, input logic [AW-1:0] a);
    if (shadow.exists(key_of(s, a))) return shadow[key_of(s, a)];
    return 'x;
  endfunction

  function automatic int lat(input logic s);
    return (s ? 3 : 1) + XO;
  endfunction

  // Read-data scoreboard: every valid beat must match the next queued value.
  always @(negedge clk) begin
    #2;
    if (rst_n && rv_s) begin
      if (first_val < 0) first_val = cyc_n;
      last_val = cyc_n;
      nval++;
      if (sbq.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL rdata_valid: got unexpected valid, expected none (cycle %0d, sel %0d)", cyc_n, sel);
      end else begin
        mon_exp = sbq.pop_front();
        chkw("rdata_out", 32'(ro_s), 32'(mon_exp));
      end
    end
  end

  task automatic check_reset_outputs();
    chk1("rst_req_ready", rr_s, 1'b1);
    chk1("rst_enb", en_s, 1'b0);
    chk1("rst_web", we_s, 1'b0);
    chk1("rst_wdata_ack", ack_s, 1'b0);
    chk1("rst_rdata_valid", rv_s, 1'b0);
    chk1("rst_busy", bz_s, 1'b0);
    chk1("rst_done", dn_s, 1'b0);
    chkw("rst_addrb", 32'(ab_s), 32'd0);
    chkw("rst_wdata_out", 32'(wo_s), 32'd0);
`ifdef BRAM_CTRL_OUT_REG_EN
    chkw("rst_rdata_out", 32'(ro_s), 32'd0);
`endif
  endtask

  task automatic run_burst(input vec_t v);
    int beats = 0;
    int done_c = -1;
    int last_beat = -1;
    int first_beat = -1;
    int abort_c = -1;
    int exp_done;
    logic [AW-1:0] a = v.addr;
    sel = v.sel;
    nval = 0;
    first_val = -1;
    last_val = -1;
    if (!v.wr)
      for (int k = 0; k < v.exp_beats; k++) sbq.push_back(exp_rd(v.sel, v.addr + AW'(k)));
    @(negedge clk);
    req_valid = 1'b1; req_wr = v.wr; req_addr = v.addr; req_len = v.len; abort = v.abort_on_req;
    #1 chk1("req_ready_idle", rr_s, 1'b1);
    @(negedge clk);
    req_valid = 1'b0; req_wr = 1'($urandom); req_addr = AW'($urandom); req_len = LW'($urandom);
    for (int i = 0; i < 400 && done_c < 0; i++) begin
      abort = (i + 1 == v.abort_at);
      if (abort) abort_c = cyc_n;
      wdata_in = DW'($urandom);
      #1;
      if (i == 0) begin
        chk1("busy_run", bz_s, 1'b1);
        chk1("req_ready_run", rr_s, 1'b0);
      end
      if (en_s) begin
        beats++;
        last_beat = cyc_n;
        if (first_beat < 0) first_beat = cyc_n;
        chkw("addrb", 32'(ab_s), 32'(a));
        chk1("web", we_s, v.wr);
        chk1("wdata_ack", ack_s, v.wr);
        if (v.wr) begin
          chkw("wdata_out", 32'(wo_s), 32'(wdata_in));
          shadow[key_of(v.sel, a)] = wdata_in;
        end
        a = a + AW'(1);
      end else begin
        chk1("web_no_beat", we_s, 1'b0);
        chk1("ack_no_beat", ack_s, 1'b0);
      end
      if (dn_s) done_c = cyc_n;
      else @(negedge clk);
    end
    abort = 1'b0;
    #2;
    nchk++;
    if (done_c < 0) begin
      nfail++;
      $display("FAIL done_timeout: got no done, expected done within 400 cycles (sel %0d)", sel);
    end
    chkw("beat_count", beats, v.exp_beats);
    chkw("valid_count", nval, v.wr ? 0 : v.exp_beats);
    chkw("scoreboard_left", sbq.size(), 0);
    sbq.delete();
    if (v.wr) exp_done = (abort_c >= 0) ? abort_c + 1 : last_beat + 1;
    else      exp_done = (nval > 0) ? last_val + 1 : abort_c + 1;
    chkw("done_cycle", done_c, exp_done);
    if (!v.wr && nval > 0) chkw("read_latency", first_val, first_beat + lat(v.sel));
    @(negedge clk);
    #1;
    chk1("done_one_cycle", dn_s, 1'b0);
    chk1("req_ready_after", rr_s, 1'b1);
  endtask

  initial begin
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0; abort = 1'b0; wdata_in = '0;
    //        sel   wr    addr       len     ab  ab_req beats
    tv[0]  = '{1'b0, 1'b1, 17'h00010, 8'd3,   0, 1'b0, 4};
    tv[1]  = '{1'b0, 1'b0, 17'h00010, 8'd3,   0, 1'b0, 4};
    tv[2]  = '{1'b0, 1'b1, 17'h1FFFE, 8'd2,   0, 1'b0, 3};
    tv[3]  = '{1'b0, 1'b0, 17'h1FFFE, 8'd2,   0, 1'b0, 3};
    tv[4]  = '{1'b0, 1'b1, 17'h00100, 8'd7,   0, 1'b0, 8};
    tv[5]  = '{1'b0, 1'b0, 17'h00100, 8'd7,   3, 1'b0, 2};
    tv[6]  = '{1'b0, 1'b0, 17'h00104, 8'd0,   2, 1'b1, 1};
    tv[7]  = '{1'b0, 1'b1, 17'h00300, 8'd4,   2, 1'b0, 1};
    tv[8]  = '{1'b0, 1'b0, 17'h00100, 8'd7,   1, 1'b0, 0};
    tv[9]  = '{1'b0, 1'b1, 17'h00400, 8'd255, 0, 1'b0, 256};
    tv[10] = '{1'b0, 1'b0, 17'h00400, 8'd255, 0, 1'b0, 256};
    tv[11] = '{1'b1, 1'b1, 17'h00555, 8'd0,   0, 1'b0, 1};
    tv[12] = '{1'b1, 1'b0, 17'h00555, 8'd0,   0, 1'b0, 1};
    tv[13] = '{1'b0, 1'b1, 17'h00700, 8'd4,   0, 1'b0, 5};
    tv[14] = '{1'b1, 1'b1, 17'h00010, 8'd2,   0, 1'b0, 3};
    tv[15] = '{1'b1, 1'b0, 17'h00010, 8'd2,   0, 1'b0, 3};
    rst_vec = '{1'b0, 1'b0, 17'h00700, 8'd4, 0, 1'b0, 5};

    repeat (2) @(negedge clk);
    #1 check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 16; t++) run_burst(tv[t]);

    // Reset asserted during the second beat of a 5-beat read.
    sel = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 17'h00700; req_len = 8'd4;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #1 chk1("beat2_enb", en_s, 1'b1);
    rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      chk1("post_rst_done", dn_s, 1'b0);
      chk1("post_rst_busy", bz_s, 1'b0);
    end
    run_burst(rst_vec);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected end of test by 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
